// File: rtl/i2c_txn_arbiter.sv
// Round-robin arbiter (optional requester-0 priority) feeding one I2C transaction engine.
// Latency: grant registered one cycle after the IDLE sample; response one cycle after m_done or timeout.
// Backpressure: command held on m_* until m_ready; other requests wait until the FSM returns to IDLE.
module i2c_txn_arbiter #(
  parameter int NREQ    = 3,
  parameter int HIPRI0  = 1,
  parameter int TIMEOUT = 4096
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*7-1:0]       req_addr,
  input  logic [NREQ-1:0]         req_rnw,
  input  logic [NREQ*8-1:0]       req_reg,
  input  logic [NREQ*8-1:0]       req_wdata,
  output logic [NREQ-1:0]         rsp_valid,
  output logic [7:0]              rsp_rdata,
  output logic                    rsp_err,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [6:0]              m_addr,
  output logic                    m_rnw,
  output logic [7:0]              m_reg,
  output logic [7:0]              m_wdata,
  input  logic                    m_done,
  input  logic                    m_nack,
  input  logic [7:0]              m_rdata,
  output logic                    busy,
  output logic [$clog2(NREQ)-1:0] grant_id
);

  localparam int GW = $clog2(NREQ);
  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t        state;
  logic [GW-1:0] last_grant;
  logic [CW-1:0] cnt;
  logic [GW-1:0] win;
  logic          win_vld;

  logic [6:0] addr_a  [NREQ];
  logic [7:0] reg_a   [NREQ];
  logic [7:0] wdata_a [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign addr_a[i]  = req_addr[7*i +: 7];
    assign reg_a[i]   = req_reg[8*i +: 8];
    assign wdata_a[i] = req_wdata[8*i +: 8];
  end

  function automatic logic [GW-1:0] rr_idx(input logic [GW-1:0] base, input int off);
    return GW'((int'(base) + off) % NREQ);
  endfunction

  // Scan from the farthest offset down so the nearest requester after last_grant is assigned last.
  always_comb begin
    win     = '0;
    win_vld = |req_valid;
    for (int i = NREQ; i >= 1; i--) begin
      if (req_valid[rr_idx(last_grant, i)]) win = rr_idx(last_grant, i);
    end
    if (HIPRI0 != 0 && req_valid[0]) win = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= GW'(NREQ-1);
      cnt        <= '0;
      req_ready  <= '0;
      rsp_valid  <= '0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
      m_valid    <= 1'b0;
      m_addr     <= '0;
      m_rnw      <= 1'b0;
      m_reg      <= '0;
      m_wdata    <= '0;
      busy       <= 1'b0;
      grant_id   <= '0;
    end else begin
      req_ready <= '0;
      rsp_valid <= '0;
      case (state)
        IDLE: begin
          if (win_vld) begin
            state     <= ISSUE;
            busy      <= 1'b1;
            grant_id  <= win;
            req_ready <= NREQ'(1) << win;
            m_valid   <= 1'b1;
            m_addr    <= addr_a[win];
            m_rnw     <= req_rnw[win];
            m_reg     <= reg_a[win];
            m_wdata   <= wdata_a[win];
          end
        end
        ISSUE: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            cnt     <= '0;
            state   <= WAIT;
          end
        end
        WAIT: begin
          // A completion on the final count takes precedence over the timeout.
          if (m_done) begin
            rsp_rdata <= m_rnw ? m_rdata : 8'h00;
            rsp_err   <= m_nack;
            rsp_valid <= NREQ'(1) << grant_id;
            state     <= RESP;
          end else if (cnt == CW'(TIMEOUT-1)) begin
            rsp_rdata <= 8'h00;
            rsp_err   <= 1'b1;
            rsp_valid <= NREQ'(1) << grant_id;
            state     <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          last_grant <= grant_id;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Directed bench: dut0 is pure round-robin, dut1 has requester-0 priority; both use TIMEOUT=16.
module tb_i2c_txn_arbiter;

  typedef struct packed {
    logic [2:0] vec;
    logic       prev_busy;
    logic [7:0] rdata;
    logic       err;
    int         cyc;
  } ev_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  req_valid [2] = '{3'b000, 3'b000};
  logic [2:0]  req_ready [2];
  logic [20:0] req_addr  [2];
  logic [2:0]  req_rnw   [2];
  logic [23:0] req_reg   [2];
  logic [23:0] req_wdata [2];
  logic [2:0]  rsp_valid [2];
  logic [7:0]  rsp_rdata [2];
  logic        rsp_err   [2];
  logic        m_valid   [2];
  logic        m_ready   [2];
  logic [6:0]  m_addr    [2];
  logic        m_rnw     [2];
  logic [7:0]  m_reg     [2];
  logic [7:0]  m_wdata   [2];
  logic        m_done    [2];
  logic        m_nack    [2];
  logic [7:0]  m_rdata   [2];
  logic        busy      [2];
  logic [1:0]  grant_id  [2];

  i2c_txn_arbiter #(.NREQ(3), .HIPRI0(0), .TIMEOUT(16)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_addr(req_addr[0]),
    .req_rnw(req_rnw[0]), .req_reg(req_reg[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]),
    .m_valid(m_valid[0]), .m_ready(m_ready[0]), .m_addr(m_addr[0]), .m_rnw(m_rnw[0]),
    .m_reg(m_reg[0]), .m_wdata(m_wdata[0]), .m_done(m_done[0]), .m_nack(m_nack[0]),
    .m_rdata(m_rdata[0]), .busy(busy[0]), .grant_id(grant_id[0])
  );

  i2c_txn_arbiter #(.NREQ(3), .HIPRI0(1), .TIMEOUT(16)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_addr(req_addr[1]),
    .req_rnw(req_rnw[1]), .req_reg(req_reg[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]),
    .m_valid(m_valid[1]), .m_ready(m_ready[1]), .m_addr(m_addr[1]), .m_rnw(m_rnw[1]),
    .m_reg(m_reg[1]), .m_wdata(m_wdata[1]), .m_done(m_done[1]), .m_nack(m_nack[1]),
    .m_rdata(m_rdata[1]), .busy(busy[1]), .grant_id(grant_id[1])
  );

  int checks = 0;
  int errors = 0;

  // Owned by the negedge model process.
  int         cyc = 0;
  int         gn [2] = '{0, 0};
  int         rn [2] = '{0, 0};
  int         hs_cyc [2] = '{0, 0};
  int         rr_long [2] = '{0, 0};
  int         ecnt [2] = '{0, 0};
  int         seen_seq [2] = '{0, 0};
  logic       ephase [2] = '{1'b0, 1'b0};
  logic       prev_busy [2] = '{1'b0, 1'b0};
  logic [2:0] prev_rr [2] = '{3'b000, 3'b000};
  ev_t        gev [2][64];
  ev_t        rev [2][64];

  // Owned by the stimulus tasks.
  int         load_seq [2] = '{0, 0};
  logic [2:0] load_vld [2] = '{3'b000, 3'b000};
  logic [2:0] hold [2] = '{3'b000, 3'b000};
  logic [2:0] reass [2] = '{3'b000, 3'b000};
  int         rdy_dly = 1;
  int         done_dly = 1;
  logic       done_en = 1'b1;
  logic       eng_nack = 1'b0;
  logic [7:0] eng_rdata = 8'h00;

  // Requesters, I2C engine and event recorder for both DUTs, all driven on the falling edge.
  always @(negedge clk) begin
    cyc = cyc + 1;
    for (int k = 0; k < 2; k++) begin
      m_ready[k] = 1'b0;
      m_done[k]  = 1'b0;
      m_nack[k]  = eng_nack;
      m_rdata[k] = eng_rdata;
      if (req_ready[k] != 3'b000) begin
        if (prev_rr[k] != 3'b000) rr_long[k]++;
        if (gn[k] < 64) gev[k][gn[k]] = '{vec: req_ready[k], prev_busy: prev_busy[k], rdata: 8'h00, err: 1'b0, cyc: cyc};
        gn[k]++;
      end
      if (rsp_valid[k] != 3'b000) begin
        if (rn[k] < 64) rev[k][rn[k]] = '{vec: rsp_valid[k], prev_busy: prev_busy[k], rdata: rsp_rdata[k], err: rsp_err[k], cyc: cyc};
        rn[k]++;
      end
      prev_rr[k]   = req_ready[k];
      prev_busy[k] = busy[k];
      if (seen_seq[k] != load_seq[k]) begin
        req_valid[k] = load_vld[k];
        seen_seq[k]  = load_seq[k];
      end else begin
        req_valid[k] = (req_valid[k] & ~(req_ready[k] & ~hold[k])) | (rsp_valid[k] & reass[k]);
      end
      if (!rst_n) begin
        ephase[k] = 1'b0;
        ecnt[k]   = 0;
      end else if (!ephase[k]) begin
        if (m_valid[k]) begin
          if (ecnt[k] >= rdy_dly) begin
            m_ready[k] = 1'b1;
            ephase[k]  = 1'b1;
            ecnt[k]    = 0;
            hs_cyc[k]  = cyc + 1;
          end else begin
            ecnt[k]++;
          end
        end
      end else if (!busy[k]) begin
        ephase[k] = 1'b0;
        ecnt[k]   = 0;
      end else if (done_en && ecnt[k] >= done_dly) begin
        m_done[k] = 1'b1;
        ephase[k] = 1'b0;
        ecnt[k]   = 0;
      end else begin
        ecnt[k]++;
      end
    end
  end

  function automatic logic [42:0] outs(input int k);
    return {req_ready[k], rsp_valid[k], rsp_rdata[k], rsp_err[k], m_valid[k], m_addr[k],
            m_rnw[k], m_reg[k], m_wdata[k], busy[k], grant_id[k]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int k, input logic [2:0] v);
    load_vld[k] = v;
    load_seq[k]++;
  endtask

  task automatic set_req(input int k, input int i, input logic [6:0] a, input logic rnw,
                         input logic [7:0] r, input logic [7:0] w);
    req_addr[k][7*i +: 7]  = a;
    req_rnw[k][i]          = rnw;
    req_reg[k][8*i +: 8]   = r;
    req_wdata[k][8*i +: 8] = w;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      hold[k]  = 3'b000;
      reass[k] = 3'b000;
      load(k, 3'b000);
    end
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic wait_cnt(input int k, input bit rsp, input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if ((rsp ? rn[k] : gn[k]) >= target) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic wait_idle(input int k, output bit ok);
    int quiet;
    quiet = 0;
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      quiet = busy[k] ? 0 : quiet + 1;
      if (quiet >= 3) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    repeat (3) tick();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (outs(k) !== 43'd0) begin
        errors++;
        $display("FAIL reset_outputs dut%0d got %h want 0", k, outs(k));
      end
    end
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_v [4];
    int gb, rb, lb;
    bit ok;
    exp_v = '{3'b001, 3'b010, 3'b100, 3'b001};
    do_reset();
    for (int i = 0; i < 3; i++) set_req(0, i, 7'(8'h40 + i), 1'b0, 8'(i), 8'(8'h80 + i));
    rdy_dly = 1; done_dly = 1; done_en = 1'b1; eng_nack = 1'b0; eng_rdata = 8'h3C;
    gb = gn[0]; rb = rn[0]; lb = rr_long[0];
    hold[0] = 3'b111;
    load(0, 3'b111);
    wait_cnt(0, 1'b1, rb + 4, 400, ok);
    hold[0] = 3'b000;
    load(0, 3'b000);
    checks++;
    if (!ok) begin errors++; $display("FAIL rr_responses got %0d want 4", rn[0] - rb); end
    wait_idle(0, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rr_idle busy stuck got 1 want 0"); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (gev[0][gb+i].vec !== exp_v[i]) begin
        errors++; $display("FAIL rr_grant%0d got %b want %b", i, gev[0][gb+i].vec, exp_v[i]);
      end
      checks++;
      if (gev[0][gb+i].prev_busy !== 1'b0) begin
        errors++; $display("FAIL rr_ready_timing%0d busy before grant got 1 want 0", i);
      end
      checks++;
      if ({rev[0][rb+i].vec, rev[0][rb+i].err} !== {exp_v[i], 1'b0}) begin
        errors++; $display("FAIL rr_rsp%0d got vec=%b err=%b want vec=%b err=0",
                           i, rev[0][rb+i].vec, rev[0][rb+i].err, exp_v[i]);
      end
    end
    checks++;
    if (rr_long[0] != lb) begin
      errors++; $display("FAIL rr_ready_width long pulses got %0d want 0", rr_long[0] - lb);
    end
  endtask

  task automatic test_hipri();
    logic [2:0] exp_v [4];
    int gb;
    bit ok;
    for (int k = 1; k >= 0; k--) begin
      if (k == 1) exp_v = '{3'b001, 3'b001, 3'b001, 3'b001};
      else        exp_v = '{3'b001, 3'b010, 3'b001, 3'b010};
      do_reset();
      gb = gn[k];
      hold[k]  = 3'b010;
      reass[k] = 3'b001;
      load(k, 3'b011);
      wait_cnt(k, 1'b0, gb + 4, 400, ok);
      hold[k]  = 3'b000;
      reass[k] = 3'b000;
      load(k, 3'b000);
      checks++;
      if (!ok) begin errors++; $display("FAIL hipri%0d_grants got %0d want 4", k, gn[k] - gb); end
      wait_idle(k, ok);
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (gev[k][gb+i].vec !== exp_v[i]) begin
          errors++; $display("FAIL hipri%0d_grant%0d got %b want %b", k, i, gev[k][gb+i].vec, exp_v[i]);
        end
      end
    end
  endtask

  task automatic test_read();
    int rb;
    bit ok;
    do_reset();
    set_req(0, 0, 7'h11, 1'b0, 8'h01, 8'h02);
    set_req(0, 1, 7'h20, 1'b1, 8'h05, 8'h77);
    set_req(0, 2, 7'h33, 1'b0, 8'h09, 8'h0A);
    eng_rdata = 8'hA5; eng_nack = 1'b0; rdy_dly = 2; done_dly = 1;
    rb = rn[0];
    load(0, 3'b010);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (req_ready[0] != 3'b000) begin ok = 1'b1; break; end
      tick();
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL read_grant no req_ready got 0 want 010"); end
    checks++;
    if ({req_ready[0], m_valid[0], m_addr[0], m_rnw[0], m_reg[0], grant_id[0]} !==
        {3'b010, 1'b1, 7'h20, 1'b1, 8'h05, 2'd1}) begin
      errors++; $display("FAIL read_issue got rdy=%b v=%b a=%h rnw=%b reg=%h gid=%0d want 010 1 20 1 05 1",
                         req_ready[0], m_valid[0], m_addr[0], m_rnw[0], m_reg[0], grant_id[0]);
    end
    wait_cnt(0, 1'b1, rb + 1, 100, ok);
    checks++;
    if (!ok || {rev[0][rb].vec, rev[0][rb].rdata, rev[0][rb].err} !== {3'b010, 8'hA5, 1'b0}) begin
      errors++; $display("FAIL read_rsp got vec=%b rdata=%h err=%b want 010 a5 0",
                         rev[0][rb].vec, rev[0][rb].rdata, rev[0][rb].err);
    end
    wait_idle(0, ok);
  endtask

  task automatic test_write_nack();
    int rb, held, bad;
    bit ok;
    do_reset();
    set_req(0, 2, 7'h3C, 1'b0, 8'h10, 8'h99);
    eng_nack = 1'b1; eng_rdata = 8'h5A; rdy_dly = 50; done_dly = 1;
    rb = rn[0];
    load(0, 3'b100);
    for (int i = 0; i < 20; i++) begin
      if (req_ready[0] != 3'b000) break;
      tick();
    end
    held = 0; bad = 0;
    for (int i = 0; i < 200; i++) begin
      if (!m_valid[0]) break;
      held++;
      if ({m_addr[0], m_rnw[0], m_reg[0], m_wdata[0]} !== {7'h3C, 1'b0, 8'h10, 8'h99}) bad++;
      if (rn[0] != rb) bad++;
      tick();
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL wr_stable unstable cycles got %0d want 0", bad); end
    checks++;
    if (held < 50) begin errors++; $display("FAIL wr_hold m_valid cycles got %0d want >=50", held); end
    wait_cnt(0, 1'b1, rb + 1, 100, ok);
    checks++;
    if (!ok || {rev[0][rb].vec, rev[0][rb].rdata, rev[0][rb].err} !== {3'b100, 8'h00, 1'b1}) begin
      errors++; $display("FAIL wr_nack_rsp got vec=%b rdata=%h err=%b want 100 00 1",
                         rev[0][rb].vec, rev[0][rb].rdata, rev[0][rb].err);
    end
    checks++;
    if (rev[0][rb].cyc - hs_cyc[0] != 2) begin
      errors++; $display("FAIL wr_done_latency got %0d want 2", rev[0][rb].cyc - hs_cyc[0]);
    end
    wait_idle(0, ok);
    eng_nack = 1'b0; rdy_dly = 1;
  endtask

  task automatic test_timeout();
    int gb, rb;
    bit ok;
    do_reset();
    set_req(0, 0, 7'h50, 1'b1, 8'h22, 8'h00);
    set_req(0, 1, 7'h51, 1'b0, 8'h23, 8'h44);
    done_en = 1'b0; rdy_dly = 0; eng_rdata = 8'hFF;
    gb = gn[0]; rb = rn[0];
    load(0, 3'b011);
    wait_cnt(0, 1'b1, rb + 1, 100, ok);
    checks++;
    if (!ok || {rev[0][rb].vec, rev[0][rb].rdata, rev[0][rb].err} !== {3'b001, 8'h00, 1'b1}) begin
      errors++; $display("FAIL to_rsp got vec=%b rdata=%h err=%b want 001 00 1",
                         rev[0][rb].vec, rev[0][rb].rdata, rev[0][rb].err);
    end
    checks++;
    if (rev[0][rb].cyc - hs_cyc[0] != 16) begin
      errors++; $display("FAIL to_latency got %0d want 16", rev[0][rb].cyc - hs_cyc[0]);
    end
    wait_cnt(0, 1'b0, gb + 2, 100, ok);
    checks++;
    if (!ok || gev[0][gb+1].vec !== 3'b010) begin
      errors++; $display("FAIL to_next_grant got %b want 010", gev[0][gb+1].vec);
    end
    wait_cnt(0, 1'b1, rb + 2, 100, ok);
    checks++;
    if (!ok || {rev[0][rb+1].vec, rev[0][rb+1].err} !== {3'b010, 1'b1}) begin
      errors++; $display("FAIL to_second_rsp got vec=%b err=%b want 010 1", rev[0][rb+1].vec, rev[0][rb+1].err);
    end
    wait_idle(0, ok);
    done_en = 1'b1; rdy_dly = 1;
  endtask

  task automatic test_reset_mid();
    int gb, rb;
    bit ok;
    do_reset();
    done_en = 1'b0; rdy_dly = 0;
    gb = gn[0]; rb = rn[0];
    load(0, 3'b001);
    wait_cnt(0, 1'b0, gb + 1, 50, ok);
    repeat (3) tick();
    checks++;
    if (!ok || {busy[0], m_valid[0]} !== 2'b10) begin
      errors++; $display("FAIL rst_pre_wait got busy=%b m_valid=%b want 1 0", busy[0], m_valid[0]);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (outs(0) !== 43'd0) begin
      errors++; $display("FAIL rst_async_outputs got %h want 0", outs(0));
    end
    load(0, 3'b100);
    repeat (3) tick();
    checks++;
    if (rn[0] != rb) begin
      errors++; $display("FAIL rst_no_rsp got %0d responses want 0", rn[0] - rb);
    end
    rst_n = 1'b1;
    wait_cnt(0, 1'b0, gb + 2, 50, ok);
    checks++;
    if (!ok || gev[0][gb+1].vec !== 3'b100) begin
      errors++; $display("FAIL rst_first_grant got %b want 100", gev[0][gb+1].vec);
    end
    wait_idle(0, ok);
    done_en = 1'b1; rdy_dly = 1;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      req_addr[k] = '0; req_rnw[k] = '0; req_reg[k] = '0; req_wdata[k] = '0;
    end
    test_reset();
    test_round_robin();
    test_hipri();
    test_read();
    test_write_nack();
    test_timeout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
